// File: rtl/matmul_pkg.sv
// Shared constants and types for the 3x3 matmul operand feeder.
package matmul_pkg;
  localparam int N  = 3;
  localparam int DW = 4;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLR,
    ST_FEED,
    ST_DRAIN,
    ST_DONE
  } state_e;
endpackage

// File: rtl/matmul_opbuf.sv
// A/B operand register file: one element write port, k-indexed column-of-A / row-of-B read.
module matmul_opbuf
  import matmul_pkg::*;
#(
  parameter int DW = matmul_pkg::DW
) (
  input  logic                   clk,
  input  logic                   clear,
  input  logic                   wr_en,
  input  logic                   wr_sel,
  input  logic [1:0]             wr_row,
  input  logic [1:0]             wr_col,
  input  logic [DW-1:0]          wr_data,
  input  logic [1:0]             rd_k,
  output logic [N-1:0][DW-1:0]   rd_w,
  output logic [N-1:0][DW-1:0]   rd_x
);
  logic [N-1:0][N-1:0][DW-1:0] a_q, a_d, b_q, b_d;

  always_comb begin
    a_d = a_q;
    b_d = b_q;
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) begin
        if (wr_en && wr_row == 2'(r) && wr_col == 2'(c)) begin
          if (wr_sel == SEL_A) a_d[r][c] = wr_data;
          else                 b_d[r][c] = wr_data;
        end
      end
    end
  end

  // w lanes take column k of A, x lanes take row k of B
  always_comb begin
    rd_w = '0;
    rd_x = '0;
    for (int k = 0; k < N; k++) begin
      if (rd_k == 2'(k)) begin
        for (int l = 0; l < N; l++) begin
          rd_w[l] = a_q[l][k];
          rd_x[l] = b_q[k][l];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      a_q <= '0;
      b_q <= '0;
    end else begin
      a_q <= a_d;
      b_q <= b_d;
    end
  end
endmodule

// File: rtl/matmul_feeder.sv
// Operand sequencer for the 3x3 MAC array: clear, three k-slices, drain, done.
module matmul_feeder
  import matmul_pkg::*;
#(
  parameter int DW           = matmul_pkg::DW,
  parameter bit CLEAR_BEFORE = 1'b1
) (
  input  logic          clk,
  input  logic          clear,
  input  logic          wr_en,
  input  logic          wr_sel,
  input  logic [1:0]    wr_row,
  input  logic [1:0]    wr_col,
  input  logic [DW-1:0] wr_data,
  input  logic          start,
  output logic [DW-1:0] data_w1,
  output logic [DW-1:0] data_w2,
  output logic [DW-1:0] data_w3,
  output logic [DW-1:0] data_x1,
  output logic [DW-1:0] data_x2,
  output logic [DW-1:0] data_x3,
  output logic          load,
  output logic          mac_clear,
  output logic          busy,
  output logic          done,
  output logic          wr_err
);
  state_e     state_q, state_d;
  logic [1:0] k_q, k_d;
  logic       wr_ok;
  logic       load_q, load_d, mac_clear_q, mac_clear_d;
  logic       busy_q, busy_d, done_q, done_d, wr_err_q, wr_err_d;
  logic [N-1:0][DW-1:0] rd_w, rd_x;
  logic [N-1:0][DW-1:0] data_w_q, data_w_d, data_x_q, data_x_d;

  assign wr_ok = wr_en && (state_q == ST_IDLE) && (wr_row < 2'(N)) && (wr_col < 2'(N));

  matmul_opbuf #(.DW(DW)) u_opbuf (
    .clk    (clk),
    .clear  (clear),
    .wr_en  (wr_ok),
    .wr_sel (wr_sel),
    .wr_row (wr_row),
    .wr_col (wr_col),
    .wr_data(wr_data),
    .rd_k   (k_d),
    .rd_w   (rd_w),
    .rd_x   (rd_x)
  );

  // Outputs are registered from the next state so they line up with the state they describe.
  // DONE is the idle-equivalent slot of a back-to-back run, so it also samples start.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        if (start) begin
          state_d = CLEAR_BEFORE ? ST_CLR : ST_FEED;
          k_d     = '0;
        end
      end
      ST_CLR: begin
        state_d = ST_FEED;
        k_d     = '0;
      end
      ST_FEED: begin
        if (k_q == 2'(N - 1)) begin
          state_d = ST_DRAIN;
          k_d     = '0;
        end else begin
          k_d = k_q + 2'd1;
        end
      end
      ST_DRAIN: state_d = ST_DONE;
      default:  state_d = ST_IDLE;
    endcase

    load_d      = (state_d == ST_FEED);
    mac_clear_d = (state_d == ST_CLR);
    busy_d      = (state_d == ST_CLR) || (state_d == ST_FEED) || (state_d == ST_DRAIN);
    done_d      = (state_d == ST_DONE);
    wr_err_d    = wr_en && !wr_ok;
  end

  always_comb begin
    data_w_d = '0;
    data_x_d = '0;
    if (load_d) begin
      data_w_d = rd_w;
      data_x_d = rd_x;
    end
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      state_q     <= ST_IDLE;
      k_q         <= '0;
      load_q      <= 1'b0;
      mac_clear_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      wr_err_q    <= 1'b0;
      data_w_q    <= '0;
      data_x_q    <= '0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      load_q      <= load_d;
      mac_clear_q <= mac_clear_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      wr_err_q    <= wr_err_d;
      data_w_q    <= data_w_d;
      data_x_q    <= data_x_d;
    end
  end

  assign data_w1   = data_w_q[0];
  assign data_w2   = data_w_q[1];
  assign data_w3   = data_w_q[2];
  assign data_x1   = data_x_q[0];
  assign data_x2   = data_x_q[1];
  assign data_x3   = data_x_q[2];
  assign load      = load_q;
  assign mac_clear = mac_clear_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign wr_err    = wr_err_q;
endmodule

// File: tb/tb_matmul_feeder.sv
// Directed bench for matmul_feeder with a behavioural 3x3 MAC array behind each instance.
module tb_matmul_feeder;
  logic       clk = 1'b0;
  logic       clear = 1'b1, wr_en = 1'b0, wr_sel = 1'b0, start = 1'b0;
  logic [1:0] wr_row = 2'd0, wr_col = 2'd0;
  logic [3:0] wr_data = 4'd0;

  logic [3:0] w1, w2, w3, x1, x2, x3, w01, w02, w03, x01, x02, x03;
  logic       load, mclr, busy, done, werr, load0, mclr0, busy0, done0, werr0;

  matmul_feeder #(.DW(4), .CLEAR_BEFORE(1'b1)) dut (
    .clk(clk), .clear(clear), .wr_en(wr_en), .wr_sel(wr_sel), .wr_row(wr_row),
    .wr_col(wr_col), .wr_data(wr_data), .start(start),
    .data_w1(w1), .data_w2(w2), .data_w3(w3), .data_x1(x1), .data_x2(x2), .data_x3(x3),
    .load(load), .mac_clear(mclr), .busy(busy), .done(done), .wr_err(werr));

  matmul_feeder #(.DW(4), .CLEAR_BEFORE(1'b0)) dut0 (
    .clk(clk), .clear(clear), .wr_en(wr_en), .wr_sel(wr_sel), .wr_row(wr_row),
    .wr_col(wr_col), .wr_data(wr_data), .start(start),
    .data_w1(w01), .data_w2(w02), .data_w3(w03), .data_x1(x01), .data_x2(x02), .data_x3(x03),
    .load(load0), .mac_clear(mclr0), .busy(busy0), .done(done0), .wr_err(werr0));

  always #5 clk = ~clk;

  logic [3:0] wv[3], xv[3], w0v[3], x0v[3];
  always_comb begin
    wv[0] = w1;   wv[1] = w2;   wv[2] = w3;
    xv[0] = x1;   xv[1] = x2;   xv[2] = x3;
    w0v[0] = w01; w0v[1] = w02; w0v[2] = w03;
    x0v[0] = x01; x0v[1] = x02; x0v[2] = x03;
  end

  // MAC array models: acc[i][j] += w_i * x_j mod 256 while load is high
  logic [7:0] acc[3][3], acc0[3][3];
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        if (clear || mclr) acc[i][j] <= 8'd0;
        else if (load) acc[i][j] <= acc[i][j] + 8'({4'd0, wv[i]} * {4'd0, xv[j]});
        if (clear || mclr0) acc0[i][j] <= 8'd0;
        else if (load0) acc0[i][j] <= acc0[i][j] + 8'({4'd0, w0v[i]} * {4'd0, x0v[j]});
      end
    end
  end

  int n_cmp = 0, n_err = 0;
  int r_loads, r_clears, r_done, r_dones, r_werr, r0_loads, r0_clears, r0_done;
  logic [3:0] sw[3][3], sx[3][3];
  bit mid_wr = 1'b0;

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic wr(input logic sel, input logic [1:0] r, input logic [1:0] c, input logic [3:0] d);
    wr_en = 1'b1; wr_sel = sel; wr_row = r; wr_col = c; wr_data = d;
    step();
    wr_en = 1'b0;
  endtask

  task automatic load_const(input logic sel, input logic [3:0] v);
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) wr(sel, 2'(r), 2'(c), v);
  endtask

  task automatic pulse_clear();
    clear = 1'b1; step(); clear = 1'b0; step();
  endtask

  // Single start pulse, then 8 observed cycles (index 0 = just after the start edge)
  task automatic do_run();
    r_loads = 0; r_clears = 0; r_done = -1; r_dones = 0; r_werr = 0;
    r0_loads = 0; r0_clears = 0; r0_done = -1;
    for (int a = 0; a < 3; a++) for (int b = 0; b < 3; b++) begin sw[a][b] = 4'd0; sx[a][b] = 4'd0; end
    start = 1'b1; step(); start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (load) begin
        if (r_loads < 3) for (int l = 0; l < 3; l++) begin sw[r_loads][l] = wv[l]; sx[r_loads][l] = xv[l]; end
        r_loads++;
      end
      if (mclr) r_clears++;
      if (done) begin r_dones++; if (r_done < 0) r_done = i; end
      if (werr) r_werr++;
      if (load0) r0_loads++;
      if (mclr0) r0_clears++;
      if (done0 && r0_done < 0) r0_done = i;
      if (mid_wr && i == 1) begin
        wr_en = 1'b1; wr_sel = 1'b0; wr_row = 2'd0; wr_col = 2'd2; wr_data = 4'd15;
      end else wr_en = 1'b0;
      step();
    end
  endtask

  task automatic test_reset();
    clear = 1'b1; step(); step();
    n_cmp++;
    if ({w1, w2, w3, x1, x2, x3, load, mclr, busy, done, werr} !== 29'd0) begin
      n_err++; $display("FAIL reset_outputs: got %h expected 0", {w1, w2, w3, x1, x2, x3, load, mclr, busy, done, werr});
    end
    n_cmp++;
    if ({w01, w02, w03, x01, x02, x03, load0, mclr0, busy0, done0, werr0} !== 29'd0) begin
      n_err++; $display("FAIL reset_outputs_cb0: got %h expected 0", {w01, w02, w03, x01, x02, x03, load0, mclr0, busy0, done0, werr0});
    end
    clear = 1'b0; step();
  endtask

  task automatic test_all3();
    load_const(1'b0, 4'd3);
    load_const(1'b1, 4'd3);
    do_run();
    n_cmp++; if (r_clears != 1) begin n_err++; $display("FAIL all3_mac_clear_cycles: got %0d expected 1", r_clears); end
    n_cmp++; if (r_loads != 3) begin n_err++; $display("FAIL all3_load_cycles: got %0d expected 3", r_loads); end
    n_cmp++; if (r_done != 5) begin n_err++; $display("FAIL all3_done_latency: got %0d expected 5", r_done); end
    n_cmp++; if (r_dones != 1) begin n_err++; $display("FAIL all3_done_width: got %0d expected 1", r_dones); end
    for (int k = 0; k < 3; k++)
      for (int l = 0; l < 3; l++) begin
        n_cmp++;
        if (sw[k][l] !== 4'd3 || sx[k][l] !== 4'd3) begin
          n_err++; $display("FAIL all3_slice k=%0d lane=%0d: got w=%0d x=%0d expected 3/3", k, l, sw[k][l], sx[k][l]);
        end
      end
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) begin
        n_cmp++;
        if (acc[i][j] !== 8'd27) begin n_err++; $display("FAIL all3_o%0d%0d: got %0d expected 27", i + 1, j + 1, acc[i][j]); end
      end
  endtask

  task automatic test_identity();
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) begin
        wr(1'b0, 2'(r), 2'(c), 4'(r * 3 + c + 1));
        wr(1'b1, 2'(r), 2'(c), (r == c) ? 4'd1 : 4'd0);
      end
    do_run();
    n_cmp++;
    if ({sw[1][0], sw[1][1], sw[1][2]} !== {4'd2, 4'd5, 4'd8}) begin
      n_err++; $display("FAIL ident_slice1_w: got %0d,%0d,%0d expected 2,5,8", sw[1][0], sw[1][1], sw[1][2]);
    end
    n_cmp++;
    if ({sx[1][0], sx[1][1], sx[1][2]} !== {4'd0, 4'd1, 4'd0}) begin
      n_err++; $display("FAIL ident_slice1_x: got %0d,%0d,%0d expected 0,1,0", sx[1][0], sx[1][1], sx[1][2]);
    end
    n_cmp++; if (acc[0][0] !== 8'd1) begin n_err++; $display("FAIL ident_o11: got %0d expected 1", acc[0][0]); end
    n_cmp++; if (acc[1][2] !== 8'd6) begin n_err++; $display("FAIL ident_o23: got %0d expected 6", acc[1][2]); end
    n_cmp++; if (acc[2][2] !== 8'd9) begin n_err++; $display("FAIL ident_o33: got %0d expected 9", acc[2][2]); end
    n_cmp++; if (acc[2][0] !== 8'd7) begin n_err++; $display("FAIL ident_o31: got %0d expected 7", acc[2][0]); end
  endtask

  task automatic test_accumulate();
    pulse_clear();
    load_const(1'b0, 4'd2);
    load_const(1'b1, 4'd2);
    do_run();
    n_cmp++; if (r0_clears != 0) begin n_err++; $display("FAIL cb0_mac_clear: got %0d expected 0", r0_clears); end
    n_cmp++; if (r0_done != 4) begin n_err++; $display("FAIL cb0_done_latency: got %0d expected 4", r0_done); end
    n_cmp++; if (r0_loads != 3) begin n_err++; $display("FAIL cb0_load_cycles: got %0d expected 3", r0_loads); end
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) begin
        n_cmp++;
        if (acc0[i][j] !== 8'd12) begin n_err++; $display("FAIL cb0_run1_o%0d%0d: got %0d expected 12", i + 1, j + 1, acc0[i][j]); end
      end
    do_run();
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) begin
        n_cmp++;
        if (acc0[i][j] !== 8'd24) begin n_err++; $display("FAIL cb0_run2_o%0d%0d: got %0d expected 24", i + 1, j + 1, acc0[i][j]); end
      end
    n_cmp++; if (acc[1][1] !== 8'd12) begin n_err++; $display("FAIL cb1_run2_o22: got %0d expected 12", acc[1][1]); end
  endtask

  task automatic test_wr_err();
    wr_en = 1'b1; wr_sel = 1'b0; wr_row = 2'd3; wr_col = 2'd0; wr_data = 4'd15;
    step(); wr_en = 1'b0;
    n_cmp++; if (werr !== 1'b1) begin n_err++; $display("FAIL wr_err_row3: got %b expected 1", werr); end
    step();
    n_cmp++; if (werr !== 1'b0) begin n_err++; $display("FAIL wr_err_row3_pulse: got %b expected 0", werr); end
    wr_en = 1'b1; wr_sel = 1'b1; wr_row = 2'd1; wr_col = 2'd3; wr_data = 4'd15;
    step(); wr_en = 1'b0;
    n_cmp++; if (werr !== 1'b1) begin n_err++; $display("FAIL wr_err_col3: got %b expected 1", werr); end
    step();
    mid_wr = 1'b1;
    do_run();
    mid_wr = 1'b0;
    n_cmp++; if (r_werr != 1) begin n_err++; $display("FAIL wr_err_feed: got %0d pulses expected 1", r_werr); end
    n_cmp++; if (sw[2][0] !== 4'd2) begin n_err++; $display("FAIL wr_feed_slice2: got %0d expected 2", sw[2][0]); end
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) begin
        n_cmp++;
        if (acc[i][j] !== 8'd12) begin n_err++; $display("FAIL wr_err_o%0d%0d: got %0d expected 12", i + 1, j + 1, acc[i][j]); end
      end
  endtask

  task automatic test_clear_mid();
    int dcnt;
    load_const(1'b0, 4'd3);
    load_const(1'b1, 4'd3);
    start = 1'b1; step(); start = 1'b0;
    step(); step();
    n_cmp++; if (load !== 1'b1 || w2 !== 4'd3) begin n_err++; $display("FAIL abort_pre_k1: got load=%b w2=%0d expected 1/3", load, w2); end
    clear = 1'b1; step();
    n_cmp++;
    if ({load, busy, done, mclr, w1, w2, w3, x1, x2, x3} !== 28'd0) begin
      n_err++; $display("FAIL abort_outputs: got %h expected 0", {load, busy, done, mclr, w1, w2, w3, x1, x2, x3});
    end
    clear = 1'b0;
    dcnt = 0;
    for (int i = 0; i < 8; i++) begin step(); if (done || load) dcnt++; end
    n_cmp++; if (dcnt != 0) begin n_err++; $display("FAIL abort_no_done: got %0d active cycles expected 0", dcnt); end
    do_run();
    n_cmp++; if (r_loads != 3) begin n_err++; $display("FAIL abort_rerun_loads: got %0d expected 3", r_loads); end
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if ({sw[k][0], sw[k][1], sw[k][2], sx[k][0], sx[k][1], sx[k][2]} !== 24'd0) begin
        n_err++; $display("FAIL abort_storage_zero k=%0d: got %h expected 0", k, {sw[k][0], sw[k][1], sw[k][2], sx[k][0], sx[k][1], sx[k][2]});
      end
    end
    load_const(1'b0, 4'd3);
    load_const(1'b1, 4'd3);
    do_run();
    n_cmp++; if (acc[2][1] !== 8'd27) begin n_err++; $display("FAIL abort_reload_o32: got %0d expected 27", acc[2][1]); end
    n_cmp++; if (r_done != 5) begin n_err++; $display("FAIL abort_reload_done: got %0d expected 5", r_done); end
  endtask

  task automatic test_back_to_back();
    int mci[$];
    int lc, dc;
    lc = 0; dc = 0;
    start = 1'b1;
    for (int i = 0; i < 18; i++) begin
      step();
      if (mclr) mci.push_back(i);
      if (load) lc++;
      if (done) dc++;
    end
    start = 1'b0;
    for (int i = 0; i < 12; i++) step();
    n_cmp++; if (mci.size() != 3) begin n_err++; $display("FAIL b2b_runs: got %0d expected 3", mci.size()); end
    n_cmp++;
    if (mci.size() < 3 || mci[0] != 0 || mci[1] != 6 || mci[2] != 12) begin
      n_err++; $display("FAIL b2b_period: got %0d starts, second at %0d expected 3 starts at 0,6,12", mci.size(), (mci.size() > 1) ? mci[1] : -1);
    end
    n_cmp++; if (lc != 9) begin n_err++; $display("FAIL b2b_load_cycles: got %0d expected 9", lc); end
    n_cmp++; if (dc != 3) begin n_err++; $display("FAIL b2b_done_pulses: got %0d expected 3", dc); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL b2b_idle_after: got busy=%b expected 0", busy); end
  endtask

  initial begin
    test_reset();
    test_all3();
    test_identity();
    test_accumulate();
    test_wr_err();
    test_clear_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
